usb_rx_packet_parser: RTL and testbench

- Sits directly downstream of the serial interface engine's receive byte port (RxCtrlOut/RxDataOut/RxDataOutWEn).
- Assembles the byte stream into USB packets: validates the PID, classifies the packet, and extracts token/SOF fields.
- Forwards data-packet payload with the trailing 2-byte CRC16 stripped, and reports one status pulse per packet to the host/slave controller.

---
 rtl/usb_rx_packet_parser_if.sv | 45 ++++
 rtl/usb_rx_packet_parser.sv | 234 +++++++++++++++++++++++
 tb/tb_usb_rx_packet_parser.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_packet_parser_if.sv
// Receive byte stream from the SIE and per-packet report toward the host/slave controller.
// The stats counters exist only when USB_RX_PKT_STATS_EN is defined.
interface usb_rx_packet_parser_if;
  logic [7:0]  RxCtrlIn;
  logic [7:0]  RxDataIn;
  logic        RxDataInWEn;
  logic [7:0]  dataOut;
  logic        dataOutWEn;
  logic        pktDone;
  logic [3:0]  pktPID;
  logic [6:0]  pktAddr;
  logic [3:0]  pktEndp;
  logic [10:0] pktFrameNum;
  logic [10:0] pktLength;
  logic [4:0]  pktStatus;
  logic        busy;
`ifdef USB_RX_PKT_STATS_EN
  logic [15:0] goodPktCount;
  logic [15:0] errPktCount;

  modport master (
    output RxCtrlIn, RxDataIn, RxDataInWEn,
    input  dataOut, dataOutWEn, pktDone, pktPID, pktAddr, pktEndp,
           pktFrameNum, pktLength, pktStatus, busy, goodPktCount, errPktCount
  );

  modport slave (
    input  RxCtrlIn, RxDataIn, RxDataInWEn,
    output dataOut, dataOutWEn, pktDone, pktPID, pktAddr, pktEndp,
           pktFrameNum, pktLength, pktStatus, busy, goodPktCount, errPktCount
  );
`else
  modport master (
    output RxCtrlIn, RxDataIn, RxDataInWEn,
    input  dataOut, dataOutWEn, pktDone, pktPID, pktAddr, pktEndp,
           pktFrameNum, pktLength, pktStatus, busy
  );

  modport slave (
    input  RxCtrlIn, RxDataIn, RxDataInWEn,
    output dataOut, dataOutWEn, pktDone, pktPID, pktAddr, pktEndp,
           pktFrameNum, pktLength, pktStatus, busy
  );
`endif
endinterface

// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: PID check, class/length checks, token field extraction, CRC16 strip.
// Optional good/error packet counters are enabled by defining USB_RX_PKT_STATS_EN.
module usb_rx_packet_parser #(
  parameter int MAX_PAYLOAD = 64
) (
  input logic                   clk,
  input logic                   rst,
  usb_rx_packet_parser_if.slave bus
);

  localparam logic [7:0]  CTRL_START  = 8'h00;
  localparam logic [7:0]  CTRL_STOP   = 8'h01;
  localparam logic [7:0]  CTRL_STREAM = 8'h02;
  localparam logic [10:0] MAX_LEN     = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MAX_LEN_SAT = 11'(MAX_PAYLOAD + 1);
  localparam logic [10:0] CNT_MAX     = 11'h7FF;

  typedef enum logic [1:0] {IDLE, PID, BODY, DONE} stateType;

  stateType    stateReg, stateNext;
  logic        isStart, isStream, isStop;
  logic        clearPkt, pidCapture, bodyByte, stopCapture, pidStop, finish;

  logic [3:0]  pidReg;
  logic        pidErrReg, pidStopReg, crcErrReg, bitStuffErrReg, oversizeReg;
  logic [10:0] bodyCntReg, emitCntReg;
  logic [7:0]  byte1Reg, byte2Reg, delay0Reg, delay1Reg;

  logic [7:0]  dataOutReg;
  logic        dataOutWEnReg, pktDoneReg;
  logic [3:0]  pktPIDReg;
  logic [6:0]  pktAddrReg;
  logic [3:0]  pktEndpReg;
  logic [10:0] pktFrameNumReg, pktLengthReg;
  logic [4:0]  pktStatusReg;

  logic        isToken, isData, isHandshake, tokenValid, payloadByte, lenErr;
  logic [4:0]  statusNext;
  logic [10:0] lengthNext;

  assign isStart  = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_START);
  assign isStream = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_STREAM);
  assign isStop   = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // A START seen mid-packet (or in DONE) restarts collection without reporting.
  always_comb begin
    stateNext   = stateReg;
    clearPkt    = 1'b0;
    pidCapture  = 1'b0;
    bodyByte    = 1'b0;
    stopCapture = 1'b0;
    pidStop     = 1'b0;
    finish      = 1'b0;
    case (stateReg)
      IDLE: if (isStart) begin
        stateNext = PID;
        clearPkt  = 1'b1;
      end
      PID: begin
        if (isStart) clearPkt = 1'b1;
        else if (isStream) begin
          pidCapture = 1'b1;
          stateNext  = BODY;
        end else if (isStop) begin
          pidStop   = 1'b1;
          stateNext = DONE;
        end
      end
      BODY: begin
        if (isStart) begin
          clearPkt  = 1'b1;
          stateNext = PID;
        end else if (isStream) bodyByte = 1'b1;
        else if (isStop) begin
          stopCapture = 1'b1;
          stateNext   = DONE;
        end
      end
      DONE: begin
        finish = 1'b1;
        if (isStart) begin
          clearPkt  = 1'b1;
          stateNext = PID;
        end else stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    isToken     = 1'b0;
    isData      = 1'b0;
    isHandshake = 1'b0;
    case (pidReg)
      4'h1, 4'h4, 4'h5, 4'h9, 4'hD:       isToken     = 1'b1;
      4'h3, 4'h7, 4'hB, 4'hF:             isData      = 1'b1;
      4'h2, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE: isHandshake = 1'b1;
      default: ;
    endcase
  end

  assign tokenValid  = isToken && !pidErrReg;
  assign payloadByte = isData && !pidErrReg && (bodyCntReg >= 11'd2);

  always_comb begin
    lenErr = pidStopReg;
    if (!pidErrReg && !pidStopReg) begin
      if (isToken && (bodyCntReg != 11'd2))    lenErr = 1'b1;
      if (isData && (bodyCntReg < 11'd2))      lenErr = 1'b1;
      if (isHandshake && (bodyCntReg != 11'd0)) lenErr = 1'b1;
    end
    statusNext = {oversizeReg, lenErr, bitStuffErrReg, crcErrReg, pidErrReg};
    lengthNext = '0;
    if (isData && !pidErrReg && !pidStopReg) begin
      if (oversizeReg)                  lengthNext = MAX_LEN_SAT;
      else if (bodyCntReg >= 11'd2)     lengthNext = bodyCntReg - 11'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pidReg         <= '0;
      pidErrReg      <= 1'b0;
      pidStopReg     <= 1'b0;
      crcErrReg      <= 1'b0;
      bitStuffErrReg <= 1'b0;
      oversizeReg    <= 1'b0;
      bodyCntReg     <= '0;
      emitCntReg     <= '0;
      byte1Reg       <= '0;
      byte2Reg       <= '0;
      delay0Reg      <= '0;
      delay1Reg      <= '0;
      dataOutReg     <= '0;
      dataOutWEnReg  <= 1'b0;
      pktDoneReg     <= 1'b0;
      pktPIDReg      <= '0;
      pktAddrReg     <= '0;
      pktEndpReg     <= '0;
      pktFrameNumReg <= '0;
      pktLengthReg   <= '0;
      pktStatusReg   <= '0;
    end else begin
      dataOutWEnReg <= 1'b0;
      pktDoneReg    <= 1'b0;
      if (finish) begin
        pktDoneReg     <= 1'b1;
        pktPIDReg      <= pidReg;
        pktAddrReg     <= tokenValid ? byte1Reg[6:0] : 7'd0;
        pktEndpReg     <= tokenValid ? {byte2Reg[2:0], byte1Reg[7]} : 4'd0;
        pktFrameNumReg <= tokenValid ? {byte2Reg[2:0], byte1Reg} : 11'd0;
        pktLengthReg   <= lengthNext;
        pktStatusReg   <= statusNext;
      end
      if (clearPkt) begin
        pidReg         <= '0;
        pidErrReg      <= 1'b0;
        pidStopReg     <= 1'b0;
        crcErrReg      <= 1'b0;
        bitStuffErrReg <= 1'b0;
        oversizeReg    <= 1'b0;
        bodyCntReg     <= '0;
        emitCntReg     <= '0;
        byte1Reg       <= '0;
        byte2Reg       <= '0;
        delay0Reg      <= '0;
        delay1Reg      <= '0;
      end else begin
        if (pidCapture) begin
          pidReg    <= bus.RxDataIn[3:0];
          pidErrReg <= (bus.RxDataIn[7:4] != ~bus.RxDataIn[3:0]);
        end
        if (pidStop) pidStopReg <= 1'b1;
        if (stopCapture) begin
          crcErrReg      <= bus.RxDataIn[0];
          bitStuffErrReg <= bus.RxDataIn[1];
        end
        if (bodyByte) begin
          if (bodyCntReg != CNT_MAX) bodyCntReg <= bodyCntReg + 11'd1;
          if (bodyCntReg == 11'd0) byte1Reg <= bus.RxDataIn;
          if (bodyCntReg == 11'd1) byte2Reg <= bus.RxDataIn;
          delay0Reg <= bus.RxDataIn;
          delay1Reg <= delay0Reg;
          // The oldest held byte is known not to be CRC once a newer pair has arrived.
          if (payloadByte) begin
            if (emitCntReg < MAX_LEN) begin
              dataOutReg    <= delay1Reg;
              dataOutWEnReg <= 1'b1;
              emitCntReg    <= emitCntReg + 11'd1;
            end else oversizeReg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.dataOut     = dataOutReg;
  assign bus.dataOutWEn  = dataOutWEnReg;
  assign bus.pktDone     = pktDoneReg;
  assign bus.pktPID      = pktPIDReg;
  assign bus.pktAddr     = pktAddrReg;
  assign bus.pktEndp     = pktEndpReg;
  assign bus.pktFrameNum = pktFrameNumReg;
  assign bus.pktLength   = pktLengthReg;
  assign bus.pktStatus   = pktStatusReg;
  assign bus.busy        = (stateReg != IDLE);

`ifdef USB_RX_PKT_STATS_EN
  logic [15:0] goodCntReg, errCntReg;
  logic        abortEv;

  assign abortEv = isStart && ((stateReg == PID) || (stateReg == BODY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      goodCntReg <= '0;
      errCntReg  <= '0;
    end else if (finish && (statusNext == 5'd0)) begin
      if (goodCntReg != 16'hFFFF) goodCntReg <= goodCntReg + 16'd1;
    end else if ((finish || abortEv) && (errCntReg != 16'hFFFF)) begin
      errCntReg <= errCntReg + 16'd1;
    end
  end

  assign bus.goodPktCount = goodCntReg;
  assign bus.errPktCount  = errCntReg;
`endif

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Self-checking bench for usb_rx_packet_parser: vector table, corner sequences, randomized packets vs model.
module tb_usb_rx_packet_parser;
  localparam int MAX_PAYLOAD = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_packet_parser_if bus();
  usb_rx_packet_parser #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
    logic [10:0] len;
    logic [4:0]  status;
  } pktRec;

  typedef struct {
    bit          hasPid;
    logic [7:0]  pidByte;
    int          nBody;
    logic [63:0] body;
    logic [7:0]  stopData;
    logic [3:0]  ePid;
    logic [6:0]  eAddr;
    logic [3:0]  eEndp;
    logic [10:0] eFrame;
    logic [10:0] eLen;
    logic [4:0]  eStat;
    int          eEmit;
  } vecRec;

  int         checks = 0;
  int         failures = 0;
  int         protoErr = 0;
  pktRec      pktQ[$];
  logic [7:0] dataQ[$];
  logic [7:0] txBody[$];
  logic [7:0] expPay[$];
  pktRec      expRec;
  logic       prevDone = 1'b0;

  // Collect everything the DUT reports; pktDone must be a single-cycle pulse with no data beside it.
  always @(negedge clk) begin
    pktRec m;
    if (rst) begin
      if (bus.dataOutWEn) dataQ.push_back(bus.dataOut);
      if (bus.pktDone) begin
        m.pid = bus.pktPID; m.addr = bus.pktAddr; m.endp = bus.pktEndp;
        m.frame = bus.pktFrameNum; m.len = bus.pktLength; m.status = bus.pktStatus;
        pktQ.push_back(m);
        if (bus.dataOutWEn || prevDone) protoErr = protoErr + 1;
      end
    end
    prevDone <= bus.pktDone;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.RxDataInWEn = 1'b0;
    bus.RxCtrlIn    = 8'($urandom);
    bus.RxDataIn    = 8'($urandom);
  endtask

  task automatic strobe(input logic [7:0] c, input logic [7:0] d);
    bus.RxCtrlIn    = c;
    bus.RxDataIn    = d;
    bus.RxDataInWEn = 1'b1;
    step();
    noise();
  endtask

  task automatic gap(input bit rnd);
    if (rnd) begin
      case ($urandom_range(0, 5))
        0: step();
        1: strobe(8'($urandom_range(3, 255)), 8'($urandom));
        default: ;
      endcase
    end
  endtask

  task automatic sendPkt(input bit hasPid, input logic [7:0] pidByte, input logic [7:0] stopData, input bit rnd);
    strobe(8'h00, 8'($urandom));
    gap(rnd);
    if (hasPid) begin
      strobe(8'h02, pidByte);
      gap(rnd);
    end
    foreach (txBody[i]) begin
      strobe(8'h02, txBody[i]);
      gap(rnd);
    end
    strobe(8'h01, stopData);
  endtask

  // Reference model: packet outcome straight from the PID class rules and the byte list.
  task automatic model(input bit hasPid, input logic [7:0] pidByte, input logic [7:0] stopData);
    int n, payN;
    bit pe, tok, dat, hs, lenErr, ovs;
    logic [3:0] pid;
    logic [7:0] b1, b2;
    n = txBody.size();
    expPay.delete();
    expRec = '{default: 0};
    if (!hasPid) begin
      expRec.status = 5'b01000;
      return;
    end
    pid = pidByte[3:0];
    pe  = (pidByte[7:4] != ~pidByte[3:0]);
    tok = pid inside {4'h1, 4'h9, 4'hD, 4'h5, 4'h4};
    dat = pid inside {4'h3, 4'hB, 4'h7, 4'hF};
    hs  = pid inside {4'h2, 4'hA, 4'hE, 4'h6, 4'h8, 4'hC};
    lenErr = !pe && ((tok && n != 2) || (dat && n < 2) || (hs && n != 0));
    payN = (dat && !pe && n >= 2) ? n - 2 : 0;
    ovs  = payN > MAX_PAYLOAD;
    for (int i = 0; i < payN && i < MAX_PAYLOAD; i++) expPay.push_back(txBody[i]);
    expRec.pid = pid;
    expRec.len = ovs ? 11'(MAX_PAYLOAD + 1) : 11'(payN);
    if (tok && !pe) begin
      b1 = (n > 0) ? txBody[0] : 8'h00;
      b2 = (n > 1) ? txBody[1] : 8'h00;
      expRec.addr  = b1[6:0];
      expRec.endp  = {b2[2:0], b1[7]};
      expRec.frame = {b2[2:0], b1};
    end
    expRec.status = {ovs, lenErr, stopData[1], stopData[0], pe};
  endtask

  task automatic checkResult(input string nm);
    pktRec r;
    repeat (6) step();
    chk($sformatf("%s.pktDoneCount", nm), pktQ.size(), 1);
    if (pktQ.size() >= 1) begin
      r = pktQ[0];
      chk($sformatf("%s.pid", nm), r.pid, expRec.pid);
      chk($sformatf("%s.addr", nm), r.addr, expRec.addr);
      chk($sformatf("%s.endp", nm), r.endp, expRec.endp);
      chk($sformatf("%s.frame", nm), r.frame, expRec.frame);
      chk($sformatf("%s.length", nm), r.len, expRec.len);
      chk($sformatf("%s.status", nm), r.status, expRec.status);
      $display("pkt %s pid=%h status=%b len=%0d bytes=%0d", nm, r.pid, r.status, r.len, dataQ.size());
    end
    chk($sformatf("%s.emitCount", nm), dataQ.size(), expPay.size());
    for (int i = 0; i < dataQ.size() && i < expPay.size(); i++)
      chk($sformatf("%s.byte%0d", nm, i), dataQ[i], expPay[i]);
    pktQ.delete();
    dataQ.delete();
  endtask

  vecRec vecs[13];
  logic [63:0] bodyBits;
  logic [7:0]  pb, sd;
  logic [3:0]  nib;
  int          n;
  bit          hp;

  initial begin
    vecs[0]  = '{1, 8'hE1, 2, 64'h0285,       8'h00, 4'h1, 7'h05, 4'h5, 11'h285, 11'd0, 5'h00, 0};
    vecs[1]  = '{1, 8'hC3, 5, 64'hBBAA332211, 8'h00, 4'h3, 7'h00, 4'h0, 11'h000, 11'd3, 5'h00, 3};
    vecs[2]  = '{1, 8'hD2, 0, 64'h0,          8'h03, 4'h2, 7'h00, 4'h0, 11'h000, 11'd0, 5'h06, 0};
    vecs[3]  = '{1, 8'h12, 0, 64'h0,          8'h00, 4'h2, 7'h00, 4'h0, 11'h000, 11'd0, 5'h01, 0};
    vecs[4]  = '{1, 8'hA5, 2, 64'h0534,       8'h00, 4'h5, 7'h34, 4'hA, 11'h534, 11'd0, 5'h00, 0};
    vecs[5]  = '{1, 8'h69, 1, 64'h83,         8'h00, 4'h9, 7'h03, 4'h1, 11'h083, 11'd0, 5'h08, 0};
    vecs[6]  = '{1, 8'h4B, 1, 64'h77,         8'h00, 4'hB, 7'h00, 4'h0, 11'h000, 11'd0, 5'h08, 0};
    vecs[7]  = '{1, 8'hC3, 3, 64'h030201,     8'h01, 4'h3, 7'h00, 4'h0, 11'h000, 11'd1, 5'h02, 1};
    vecs[8]  = '{1, 8'hD2, 1, 64'h55,         8'h00, 4'h2, 7'h00, 4'h0, 11'h000, 11'd0, 5'h08, 0};
    vecs[9]  = '{0, 8'h00, 0, 64'h0,          8'h00, 4'h0, 7'h00, 4'h0, 11'h000, 11'd0, 5'h08, 0};
    vecs[10] = '{1, 8'h43, 4, 64'h44332211,   8'h00, 4'h3, 7'h00, 4'h0, 11'h000, 11'd0, 5'h01, 0};
    vecs[11] = '{1, 8'h4B, 2, 64'hBBAA,       8'h00, 4'hB, 7'h00, 4'h0, 11'h000, 11'd0, 5'h00, 0};
    vecs[12] = '{1, 8'h1E, 0, 64'h0,          8'h00, 4'hE, 7'h00, 4'h0, 11'h000, 11'd0, 5'h00, 0};

    bus.RxCtrlIn = 8'h00;
    bus.RxDataIn = 8'h00;
    bus.RxDataInWEn = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) step();
    chk("reset.outputs", {bus.dataOut, bus.dataOutWEn, bus.pktDone, bus.pktPID, bus.pktAddr, bus.pktEndp,
                          bus.pktFrameNum, bus.pktLength, bus.pktStatus, bus.busy}, 64'd0);
    rst = 1'b1;
    step();

    // Table-driven vectors
    for (int v = 0; v < 13; v++) begin
      txBody.delete();
      bodyBits = vecs[v].body;
      for (int i = 0; i < vecs[v].nBody; i++) txBody.push_back(bodyBits[8*i +: 8]);
      pktQ.delete();
      dataQ.delete();
      sendPkt(vecs[v].hasPid, vecs[v].pidByte, vecs[v].stopData, 1'b0);
      expRec.pid = vecs[v].ePid; expRec.addr = vecs[v].eAddr; expRec.endp = vecs[v].eEndp;
      expRec.frame = vecs[v].eFrame; expRec.len = vecs[v].eLen; expRec.status = vecs[v].eStat;
      expPay.delete();
      for (int i = 0; i < vecs[v].eEmit; i++) expPay.push_back(bodyBits[8*i +: 8]);
      checkResult($sformatf("vec%0d", v));
    end

    // Oversize: 70 payload bytes plus CRC, only MAX_PAYLOAD forwarded
    txBody.delete();
    for (int i = 0; i < 72; i++) txBody.push_back(8'($urandom));
    pktQ.delete(); dataQ.delete();
    sendPkt(1'b1, 8'h4B, 8'h00, 1'b0);
    model(1'b1, 8'h4B, 8'h00);
    checkResult("oversize");

    // Latency and busy: pktDone two cycles after STOP, busy drops with pktDone
    pktQ.delete(); dataQ.delete();
    strobe(8'h00, 8'h00);
    chk("lat.busyAfterStart", bus.busy, 1'b1);
    strobe(8'h02, 8'hD2);
    strobe(8'h01, 8'h00);
    chk("lat.doneAt1", bus.pktDone, 1'b0);
    step();
    chk("lat.doneAt2", bus.pktDone, 1'b1);
    chk("lat.busyAtDone", bus.busy, 1'b0);
    step();
    chk("lat.doneAt3", bus.pktDone, 1'b0);
    repeat (3) step();
    pktQ.delete(); dataQ.delete();

    // Abort: a second START mid data packet yields a single report for the handshake
    strobe(8'h00, 8'h00);
    strobe(8'h02, 8'hC3);
    for (int i = 0; i < 5; i++) strobe(8'h02, 8'(8'h60 + i));
    strobe(8'h00, 8'h00);
    strobe(8'h02, 8'hD2);
    strobe(8'h01, 8'h00);
    repeat (6) step();
    chk("abort.pktDoneCount", pktQ.size(), 1);
    if (pktQ.size() >= 1) begin
      chk("abort.pid", pktQ[0].pid, 4'h2);
      chk("abort.status", pktQ[0].status, 5'h00);
      $display("pkt abort pid=%h status=%b", pktQ[0].pid, pktQ[0].status);
    end
    chk("abort.emitCount", dataQ.size(), 3);
    pktQ.delete(); dataQ.delete();

    // Asynchronous reset mid-packet, after a token left non-zero fields
    txBody.delete();
    txBody.push_back(8'h85);
    txBody.push_back(8'h02);
    sendPkt(1'b1, 8'hE1, 8'h00, 1'b0);
    repeat (4) step();
    strobe(8'h00, 8'h00);
    strobe(8'h02, 8'hC3);
    strobe(8'h02, 8'h11);
    strobe(8'h02, 8'h22);
    strobe(8'h02, 8'h33);
    #2 rst = 1'b0;
    #1;
    chk("rstMid.busy", bus.busy, 1'b0);
    chk("rstMid.outputs", {bus.dataOut, bus.dataOutWEn, bus.pktDone, bus.pktPID, bus.pktAddr, bus.pktEndp,
                           bus.pktFrameNum, bus.pktLength, bus.pktStatus, bus.busy}, 64'd0);
    step();
    rst = 1'b1;
    step();
    pktQ.delete(); dataQ.delete();

    // Randomized packets against the reference model
    for (int p = 0; p < 60; p++) begin
      nib = 4'($urandom);
      pb  = {~nib, nib};
      if ($urandom_range(0, 7) == 0) pb[7:4] = pb[7:4] ^ 4'(1 << $urandom_range(0, 3));
      hp = ($urandom_range(0, 19) != 0);
      n  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(0, 8);
      if (!hp) n = 0;
      sd = {6'($urandom), 2'($urandom_range(0, 3))};
      txBody.delete();
      for (int i = 0; i < n; i++) txBody.push_back(8'($urandom));
      pktQ.delete(); dataQ.delete();
      sendPkt(hp, pb, sd, 1'b1);
      model(hp, pb, sd);
      checkResult($sformatf("rnd%0d", p));
    end

    chk("protocol.doneOverlap", protoErr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
